// File: rtl/multi_rate_ticker.sv
// multi_rate_ticker: NUM_CH independent tick strobes with loadable divisors; define TICK_TOGGLE_EN for square-wave clk_out
module multi_rate_ticker #(
  parameter int CH_W = 2,
  parameter int CNT_W = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [2**CH_W-1:0]   enable,
  input  logic                 load,
  input  logic [CH_W-1:0]      load_ch,
  input  logic [CNT_W-1:0]     load_div,
  input  logic                 sync,
  output logic [2**CH_W-1:0]   tick,
  output logic [2**CH_W-1:0]   clk_out
);
  localparam int NUM_CH = 2**CH_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] new_div;
  assign new_div = load_div == '0 ? ONE : load_div;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] div, cnt;
    logic hit, t;
    assign hit = load && load_ch == CH_W'(c);
    assign tick[c] = t;
    always_ff @(posedge CLOCK_50)
      if (!resetn) begin
        div <= DEF;
        cnt <= DEF - ONE;
        t <= 1'b0;
      end else if (hit) begin
        div <= new_div;
        cnt <= new_div - ONE;
        t <= 1'b0;
      end else if (sync) begin
        cnt <= div - ONE;
        t <= 1'b0;
      end else if (!enable[c]) begin
        t <= 1'b0;
      end else if (cnt == '0) begin
        cnt <= div - ONE;
        t <= 1'b1;
      end else begin
        cnt <= cnt - ONE;
        t <= 1'b0;
      end
`ifdef TICK_TOGGLE_EN
    // flips together with the tick it accompanies, so half-period equals div
    logic co;
    assign clk_out[c] = co;
    always_ff @(posedge CLOCK_50)
      if (!resetn || hit || sync) co <= 1'b0;
      else if (enable[c] && cnt == '0) co <= ~co;
`else
    assign clk_out[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_multi_rate_ticker.sv
// tb_multi_rate_ticker: vector table, hand sequences and random run against a phase-count model
module tb_multi_rate_ticker;
  localparam int CH_W = 2, CNT_W = 16, N = 4, DDIV = 5, NV = 34;
  logic CLOCK_50 = 1'b0, resetn = 1'b0, load = 1'b0, sync = 1'b0;
  logic [N-1:0] enable = '0, tick, clk_out;
  logic [CH_W-1:0] load_ch = '0;
  logic [CNT_W-1:0] load_div = '0;
  int errors = 0, checks = 0;
  int m_div[N], m_ph[N], m_nt[N];
  logic [N-1:0] m_tick, m_clk;
  typedef struct {
    logic [N-1:0] en;
    logic ld;
    logic [CH_W-1:0] ch;
    logic [CNT_W-1:0] dv;
    logic sy;
    logic [N-1:0] exp;
  } vec_t;
  vec_t tbl[NV];
  logic [N-1:0] ex[NV];
  always #10 CLOCK_50 = ~CLOCK_50;
  multi_rate_ticker #(.CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .load(load),
    .load_ch(load_ch), .load_div(load_div), .sync(sync), .tick(tick), .clk_out(clk_out)
  );
  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  // Model: a channel ticks when its count of enabled edges since restart is a multiple of div
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      m_tick[i] = 1'b0;
      if (!resetn) begin
        m_div[i] = DDIV; m_ph[i] = 0; m_nt[i] = 0;
      end else if (load && int'(load_ch) == i) begin
        m_div[i] = load_div == '0 ? 1 : int'(load_div); m_ph[i] = 0; m_nt[i] = 0;
      end else if (sync) begin
        m_ph[i] = 0; m_nt[i] = 0;
      end else if (enable[i]) begin
        m_ph[i]++;
        m_tick[i] = (m_ph[i] % m_div[i]) == 0;
        if (m_tick[i]) m_nt[i]++;
      end
`ifdef TICK_TOGGLE_EN
      m_clk[i] = m_nt[i][0];
`else
      m_clk[i] = 1'b0;
`endif
    end
  endtask
  task automatic step(input logic [N-1:0] en, input logic ld, input logic [CH_W-1:0] ch,
                      input logic [CNT_W-1:0] dv, input logic sy);
    enable = en; load = ld; load_ch = ch; load_div = dv; sync = sy;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("model_tick", tick, m_tick);
    check("model_clk_out", clk_out, m_clk);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    step('1, 1'b0, '0, '0, 1'b0);
    step('1, 1'b1, 2'd1, 16'd2, 1'b1);
    check("reset_tick", tick, '0);
    check("reset_clk_out", clk_out, '0);
    resetn = 1'b1;
  endtask
  initial begin
    ex = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h4, 4'hB,
           4'h0, 4'h4, 4'h0, 4'h2, 4'hF, 4'h2, 4'h2, 4'h6, 4'h2, 4'hA,
           4'h6, 4'h2, 4'h2, 4'h6, 4'hA, 4'h2, 4'h7, 4'h0, 4'h2, 4'h2,
           4'hE, 4'h2, 4'h3, 4'hE};
    for (int k = 0; k < NV; k++) begin
      tbl[k].en = 4'hF; tbl[k].ld = 1'b0; tbl[k].ch = '0;
      tbl[k].dv = '0; tbl[k].sy = 1'b0; tbl[k].exp = ex[k];
    end
    tbl[5].ld = 1'b1; tbl[5].ch = 2'd2; tbl[5].dv = 16'd3;
    tbl[12].ld = 1'b1; tbl[12].ch = 2'd1; tbl[12].dv = 16'd0;
    for (int k = 17; k < 24; k++) tbl[k].en = 4'b1110;
    tbl[27].ld = 1'b1; tbl[27].ch = 2'd3; tbl[27].dv = 16'd3; tbl[27].sy = 1'b1;
    do_reset();
    for (int k = 0; k < NV; k++) begin
      step(tbl[k].en, tbl[k].ld, tbl[k].ch, tbl[k].dv, tbl[k].sy);
      check($sformatf("vec%0d", k + 1), tick, tbl[k].exp);
    end
    // reset mid-run restarts every phase from DEFAULT_DIV
    for (int k = 0; k < 3; k++) step('1, 1'b0, '0, '0, 1'b0);
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step('1, 1'b0, '0, '0, 1'b0);
      check($sformatf("restart_edge%0d", k), tick, (k % DDIV == 0) ? 4'hF : 4'h0);
    end
    // square-wave output with div=4 on channel 0, then forced low by sync
    step('1, 1'b1, 2'd0, 16'd4, 1'b0);
    check("clk_after_load", {3'b000, clk_out[0]}, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      step('1, 1'b0, '0, '0, 1'b0);
`ifdef TICK_TOGGLE_EN
      check($sformatf("clk0_edge%0d", k), {3'b000, clk_out[0]}, {3'b000, 1'((k / 4) % 2)});
`else
      check($sformatf("clk0_edge%0d", k), clk_out, 4'h0);
`endif
    end
    step('1, 1'b0, 2'd0, 16'd0, 1'b1);
    check("sync_tick", tick, 4'h0);
    check("sync_clk_out", clk_out, 4'h0);
    for (int k = 0; k < 3000; k++) begin
      resetn = $urandom_range(0, 199) != 0;
      step($urandom_range(0, 3) == 0 ? N'($urandom) : '1,
           $urandom_range(0, 15) == 0, CH_W'($urandom), CNT_W'($urandom_range(0, 7)),
           $urandom_range(0, 31) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_rate_ticker.md
Name: multi_rate_ticker

Overview:
- Parametrised, multi-channel successor to the single-output fixed-select clock slower.
- Produces NUM_CH independent single-cycle tick strobes from CLOCK_50.
- Each channel has a runtime-loadable divisor, a per-channel enable, and a global phase-align restart.
- Consumers are game-logic FSMs, the animation timers and VGA draw pacing. All of them run on CLOCK_50 and qualify their logic with the tick; none of them is clocked by it.

Parameters:
- CH_W, 2, channel-index width; NUM_CH = 2**CH_W channels.
- CNT_W, 32, divisor and counter width.
- DEFAULT_DIV, 50000000, divisor loaded into every channel at reset (1 Hz at 50 MHz); must be >= 1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  reset; synchronous, active-low.
- enable  in  NUM_CH  per-channel run enable; bit i gates channel i.
- load  in  1  write strobe: divisor update for channel load_ch.
- load_ch  in  CH_W  channel selected by load.
- load_div  in  CNT_W  new divisor value.
- sync  in  1  global restart; all channels realign phase.
- tick  out  NUM_CH  one-cycle strobe per channel.
- clk_out  out  NUM_CH  square-wave output; see Optional Feature.

Behaviour:
- Per-channel state:
  - div[i] (CNT_W bits), a divisor register.
  - cnt[i] (CNT_W bits), a down-counter.
  - tick[i], a registered output.
- Reset (resetn=0 at a rising edge) overrides everything:
  - div[i] = DEFAULT_DIV.
  - cnt[i] = DEFAULT_DIV-1.
  - tick = 0.
  - clk_out = 0.
- Counting, per channel, per edge, applied in this priority order:
  1. load && load_ch==i: div[i] <= (load_div==0 ? 1 : load_div); cnt[i] <= that value - 1; tick[i] <= 0.
  2. sync: cnt[i] <= div[i]-1; tick[i] <= 0.
  3. !enable[i]: cnt[i] holds; tick[i] <= 0.
  4. cnt[i]==0: tick[i] <= 1; cnt[i] <= div[i]-1.
  5. Otherwise: cnt[i] <= cnt[i]-1; tick[i] <= 0.
- load and sync on the same edge: the loaded channel takes the new divisor and its counter restarts from it. All other channels restart from their existing div. Net effect: every channel is phase-aligned.
- Period: with enable held high, tick[i] pulses exactly once per div[i] edges.
  - The first pulse is registered on the div[i]-th edge after reset release, load or sync.
- div=1: tick[i] is high continuously while enabled.
- Divisor 0 is illegal and is clamped to 1. No wrap-around of cnt below 0 is possible.
- Enable gaps pause the phase; they do not restart it. Counts accumulated before the gap are retained.
- tick is a registered output; there is no combinational path from any input to tick.
- Channels are fully independent, apart from the shared load bus and sync.

Optional Feature:
- Macro: TICK_TOGGLE_EN.
- Defined: clk_out[i] toggles on every edge where tick[i] is registered high.
  - Result: a 50%-duty square wave of period 2*div[i] cycles.
  - clk_out[i] is forced to 0 by reset, by sync, and by a load to channel i.
  - Intended for LEDs and the audio buzzer.
- Not defined: clk_out is driven constant 0 and the toggle flops are not built.

Test Plan:
- Reset, DEFAULT_DIV=5, enable=4'b1111, hold 20 cycles -> each tick bit pulses at edges 5, 10, 15, 20 after reset release, one cycle wide each.
- load=1, load_ch=2, load_div=3 -> tick[2] pulses every 3rd edge from the load; channels 0, 1 and 3 keep their original phase.
- load_div=0 to channel 1 -> treated as 1; tick[1] stays high every enabled cycle.
- enable[0] low for 7 cycles mid-count (cnt[0]=2) -> no tick[0] during the gap; the pulse arrives 3 edges after enable returns.
- sync asserted while channels are at different phases -> all tick outputs 0 that edge; all channels pulse together div edges later when the divisors are equal. A simultaneous load to channel 3 with sync uses the new divisor.
- TICK_TOGGLE_EN defined, div=4 -> clk_out toggles every 4 cycles (period 8) and is forced to 0 on sync. Macro undefined -> clk_out stays 0 throughout.
